// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control FSM that drives the register select-and-encode
// strobes and the datapath register, ALU and memory strobes from the IR opcode.
module control_sequencer #(
    parameter int unsigned OPW  = 5,
    parameter int unsigned ALUW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
    input  logic            mem_done,
    input  logic            stop,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            Cout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            Write,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            CONin,
    output logic [ALUW-1:0] alu_op,
    output logic            run,
    output logic            illegal,
    output logic [3:0]      step
);

    localparam int unsigned IRW = 32;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
    localparam logic [OPW-1:0] OP_BR   = OPW'(19);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(3);
    localparam logic [ALUW-1:0] ALU_AND = ALUW'(5);
    localparam logic [ALUW-1:0] ALU_OR  = ALUW'(6);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd15
    } state_t;

    state_t          state;
    state_t          state_next;
    state_t          end_state;
    logic            held;
    logic [OPW-1:0]  opcode;
    logic            is_ld, is_ldi, is_st, is_rr, is_imm, is_br, is_nop, is_halt, is_ill;
    logic [ALUW-1:0] imm_alu;
    logic            unused_ir_bits;

    assign opcode         = IR[IRW-1 -: OPW];
    assign unused_ir_bits = ^IR[IRW-OPW-1:0];
    assign step           = state;
    assign run            = reset | (state != HALT);

    // Instruction class decode
    always_comb begin
        is_ld   = 1'b0;
        is_ldi  = 1'b0;
        is_st   = 1'b0;
        is_rr   = 1'b0;
        is_imm  = 1'b0;
        is_br   = 1'b0;
        is_nop  = 1'b0;
        is_halt = 1'b0;
        is_ill  = 1'b0;
        imm_alu = ALU_ADD;
        case (opcode)
            OP_LD:   is_ld   = 1'b1;
            OP_LDI:  is_ldi  = 1'b1;
            OP_ST:   is_st   = 1'b1;
            OP_ADDI: is_imm  = 1'b1;
            OP_ANDI: begin is_imm = 1'b1; imm_alu = ALU_AND; end
            OP_ORI:  begin is_imm = 1'b1; imm_alu = ALU_OR;  end
            OP_BR:   is_br   = 1'b1;
            OP_NOP:  is_nop  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: begin
                if (opcode >= OP_ADD && opcode <= OP_ROL) begin
                    is_rr = 1'b1;
                end else begin
                    is_ill = 1'b1;
                end
            end
        endcase
    end

    // held marks a cycle that repeats the previous state (wait-state dwell)
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
            held  <= 1'b0;
        end else begin
            state <= state_next;
            held  <= (state_next == state);
        end
    end

    always_comb begin
        state_next = state;
        end_state  = stop ? HALT : T0;
        case (state)
            T0: state_next = T1;
            T1: if (mem_done) state_next = T2;
            T2: state_next = T3;
            T3: begin
                if (is_halt) begin
                    state_next = HALT;
                end else if (is_nop || is_ill) begin
                    state_next = end_state;
                end else begin
                    state_next = T4;
                end
            end
            T4: state_next = T5;
            T5: begin
                if (is_rr || is_imm || is_ldi) begin
                    state_next = end_state;
                end else begin
                    state_next = T6;
                end
            end
            T6: begin
                if (is_ld) begin
                    if (mem_done) state_next = T7;
                end else if (is_st) begin
                    state_next = T7;
                end else begin
                    state_next = end_state;
                end
            end
            T7: begin
                if (is_ld || mem_done) state_next = end_state;
            end
            HALT: state_next = HALT;
            default: state_next = T0;
        endcase
    end

    // Strobe decode; everything is held low while reset is asserted
    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = '0;
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write} = '0;
        {IRin, Yin, Zin, Zlowout, CONin} = '0;
        alu_op  = '0;
        illegal = 1'b0;
        if (!reset) begin
            case (state)
                T0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1; PCin = ~held; Read = 1'b1; MDRin = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                T3: begin
                    illegal = is_ill;
                    if (is_ld || is_ldi || is_st) begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end else if (is_rr || is_imm) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (is_br) begin
                        Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                    end
                end
                T4: begin
                    if (is_rr) begin
                        Grc = 1'b1; Rout = 1'b1; alu_op = ALUW'(opcode); Zin = 1'b1;
                    end else if (is_imm) begin
                        Cout = 1'b1; alu_op = imm_alu; Zin = 1'b1;
                    end else if (is_ld || is_ldi || is_st) begin
                        Cout = 1'b1; alu_op = ALU_ADD; Zin = 1'b1;
                    end else if (is_br) begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                end
                T5: begin
                    if (is_rr || is_imm || is_ldi) begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (is_ld || is_st) begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end else if (is_br) begin
                        Cout = 1'b1; alu_op = ALU_ADD; Zin = 1'b1;
                    end
                end
                T6: begin
                    if (is_ld) begin
                        Read = 1'b1; MDRin = 1'b1;
                    end else if (is_st) begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end else if (is_br) begin
                        Zlowout = 1'b1; PCin = CON_FF;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (is_st) begin
                        MDRout = 1'b1; Write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a phase-list model checked every
// cycle, plus directed instruction runs with hand-computed expectations.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset, CON_FF, mem_done, stop;
    logic [31:0] IR;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
    logic        IRin, Yin, Zin, Zlowout, CONin;
    logic [4:0]  alu_op;
    logic        run, illegal;
    logic [3:0]  step;
    logic [20:0] vec;

    control_sequencer #(.OPW(5), .ALUW(5)) dut (
        .clock(clock), .reset(reset), .IR(IR), .CON_FF(CON_FF),
        .mem_done(mem_done), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Cout(Cout), .PCout(PCout), .PCin(PCin),
        .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .CONin(CONin), .alu_op(alu_op), .run(run),
        .illegal(illegal), .step(step)
    );

    always #5 clock = ~clock;

    assign vec = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC,
                  MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout,
                  CONin, illegal};

    localparam logic [20:0] GRA    = 21'(1) << 20;
    localparam logic [20:0] GRB    = 21'(1) << 19;
    localparam logic [20:0] GRC    = 21'(1) << 18;
    localparam logic [20:0] RIN    = 21'(1) << 17;
    localparam logic [20:0] ROUT   = 21'(1) << 16;
    localparam logic [20:0] BAOUT  = 21'(1) << 15;
    localparam logic [20:0] COUT   = 21'(1) << 14;
    localparam logic [20:0] PCOUT  = 21'(1) << 13;
    localparam logic [20:0] PCIN   = 21'(1) << 12;
    localparam logic [20:0] INCPC  = 21'(1) << 11;
    localparam logic [20:0] MARIN  = 21'(1) << 10;
    localparam logic [20:0] MDRIN  = 21'(1) << 9;
    localparam logic [20:0] MDROUT = 21'(1) << 8;
    localparam logic [20:0] READ   = 21'(1) << 7;
    localparam logic [20:0] WRITE  = 21'(1) << 6;
    localparam logic [20:0] IRIN   = 21'(1) << 5;
    localparam logic [20:0] YIN    = 21'(1) << 4;
    localparam logic [20:0] ZIN    = 21'(1) << 3;
    localparam logic [20:0] ZLOW   = 21'(1) << 2;
    localparam logic [20:0] CONIN  = 21'(1) << 1;
    localparam logic [20:0] ILL    = 21'(1);

    // One timing step of an instruction as the spec tables describe it
    typedef struct {
        logic [3:0]  st;
        logic [20:0] mask;
        logic [4:0]  alu;
        bit          waits;
        bit          pc_first;
        bit          pc_cond;
        bit          halt_after;
    } phase_t;

    phase_t q[$];
    phase_t cur;
    int     dwell;
    bit     halted;
    int     checks;
    int     errors;
    bit     chk_en;

    function automatic phase_t ph(input logic [3:0] s, input logic [20:0] m,
                                  input logic [4:0] a, input bit w, input bit pf,
                                  input bit pc, input bit ha);
        phase_t p;
        p.st = s; p.mask = m; p.alu = a; p.waits = w;
        p.pc_first = pf; p.pc_cond = pc; p.halt_after = ha;
        return p;
    endfunction

    function automatic void load_fetch();
        q.delete();
        q.push_back(ph(4'd0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        q.push_back(ph(4'd1, ZLOW | PCIN | READ | MDRIN,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        q.push_back(ph(4'd2, MDROUT | IRIN,               5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endfunction

    function automatic void push_exec(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        if (op >= 5'd3 && op <= 5'd11) begin
            q.push_back(ph(4'd3, GRB | ROUT | YIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd4, GRC | ROUT | ZIN, op,   1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd5, ZLOW | GRA | RIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op >= 5'd12 && op <= 5'd14) begin
            q.push_back(ph(4'd3, GRB | ROUT | YIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd4, COUT | ZIN,
                           (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6,
                           1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd5, ZLOW | GRA | RIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op <= 5'd2) begin
            q.push_back(ph(4'd3, GRB | BAOUT | YIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd4, COUT | ZIN,        5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
            if (op == 5'd1) begin
                q.push_back(ph(4'd5, ZLOW | GRA | RIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            end else begin
                q.push_back(ph(4'd5, ZLOW | MARIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                if (op == 5'd0) begin
                    q.push_back(ph(4'd6, READ | MDRIN,        5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
                    q.push_back(ph(4'd7, MDROUT | GRA | RIN,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                end else begin
                    q.push_back(ph(4'd6, GRA | ROUT | MDRIN,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    q.push_back(ph(4'd7, MDROUT | WRITE,      5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
                end
            end
        end else if (op == 5'd19) begin
            q.push_back(ph(4'd3, GRA | ROUT | CONIN, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd4, PCOUT | YIN,        5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd5, COUT | ZIN,         5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(ph(4'd6, ZLOW,               5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else if (op == 5'd26) begin
            q.push_back(ph(4'd3, '0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op == 5'd27) begin
            q.push_back(ph(4'd3, '0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            q.push_back(ph(4'd3, ILL, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endfunction

    // Model advance: one clock edge
    initial forever begin
        @(posedge clock);
        if (reset) begin
            load_fetch();
            dwell  = 0;
            halted = 1'b0;
        end else if (!halted && q.size() > 0) begin
            cur = q[0];
            if (cur.waits && !mem_done) begin
                dwell++;
            end else begin
                void'(q.pop_front());
                dwell = 0;
                if (cur.st == 4'd2) push_exec(IR);
                if (q.size() == 0) begin
                    if (cur.halt_after || stop) halted = 1'b1;
                    else load_fetch();
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        logic [30:0] e;
        logic [30:0] a;
        logic [20:0] m;
        @(negedge clock);
        if (chk_en) begin
            if (reset) begin
                e = {halted ? 4'd15 : q[0].st, 1'b1, 5'd0, 21'd0};
            end else if (halted) begin
                e = {4'd15, 1'b0, 5'd0, 21'd0};
            end else begin
                m = q[0].mask;
                if (q[0].pc_first && dwell != 0) m = m & ~PCIN;
                if (q[0].pc_cond && CON_FF) m = m | PCIN;
                e = {q[0].st, 1'b1, q[0].alu, m};
            end
            a = {step, run, alu_op, vec};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t got step/run/alu/strobes=%h want=%h", $time, a, e);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    int          cnt[16];
    logic [20:0] snap[16];
    logic [4:0]  asnap[16];
    int          n_cyc;
    int          pcin_t1;
    bit          read_t1_all;
    bit          rin_any;

    // Runs one instruction from T0 until back at T0 or HALT, shaping mem_done
    task automatic run_instr(input logic [31:0] ir, input int t1_low,
                             input int w_low, input bit stop_at_t3);
        int s;
        IR = ir; n_cyc = 0; pcin_t1 = 0; read_t1_all = 1'b1; rin_any = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cnt[i] = 0; snap[i] = '0; asnap[i] = '0;
        end
        do begin
            s = int'(step);
            if (cnt[s] == 0) begin
                snap[s]  = vec;
                asnap[s] = alu_op;
            end
            cnt[s]++;
            if (s == 1) mem_done = (cnt[1] > t1_low);
            else if (s == 6 || s == 7) mem_done = (cnt[s] > w_low);
            else mem_done = 1'b1;
            if (s == 1) begin
                pcin_t1 += int'(PCin);
                read_t1_all &= Read;
            end
            rin_any |= Rin;
            if (s == 3 && stop_at_t3) stop = 1'b1;
            tick();
            n_cyc++;
        end while (step != 4'd0 && step != 4'd15 && n_cyc < 60);
        if (n_cyc >= 60) begin
            checks++;
            errors++;
            $display("FAIL timeout ir=%h step=%0d", ir, step);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d", step);
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0; errors = 0; chk_en = 1'b0;
        reset = 1'b1; IR = '0; CON_FF = 1'b0; mem_done = 1'b1; stop = 1'b0;
        tick();
        chk_en = 1'b1;
        lit("reset_step", 32'(step), 32'd0);
        lit("reset_run", 32'(run), 32'd1);
        tick();
        reset = 1'b0;

        run_instr(32'h691FFFFD, 0, 0, 1'b0);
        lit("andi_cycles", n_cyc, 6);
        lit("andi_t3", snap[3], GRB | ROUT | YIN);
        lit("andi_t4", snap[4], COUT | ZIN);
        lit("andi_t4_alu", asnap[4], 5'b00101);
        lit("andi_t5", snap[5], ZLOW | GRA | RIN);
        lit("andi_end_step", 32'(step), 32'd0);

        run_instr(32'h18000000, 3, 0, 1'b0);
        lit("add_t1_len", cnt[1], 4);
        lit("add_pcin_count", pcin_t1, 1);
        lit("add_read_held", 32'(read_t1_all), 32'd1);
        lit("add_t4", snap[4], GRC | ROUT | ZIN);
        lit("add_t4_alu", asnap[4], 5'b00011);
        lit("add_cycles", n_cyc, 9);

        run_instr(32'h00800005, 0, 2, 1'b0);
        lit("ld_t6_len", cnt[6], 3);
        lit("ld_t6", snap[6], READ | MDRIN);
        lit("ld_t7", snap[7], MDROUT | GRA | RIN);
        lit("ld_cycles", n_cyc, 10);

        run_instr(32'h10800005, 0, 1, 1'b0);
        lit("st_t6", snap[6], GRA | ROUT | MDRIN);
        lit("st_t7", snap[7], MDROUT | WRITE);
        lit("st_t7_len", cnt[7], 2);
        lit("st_no_rin", 32'(rin_any), 32'd0);

        CON_FF = 1'b0;
        run_instr(32'h98000003, 0, 0, 1'b0);
        lit("br_nt_t6", snap[6], ZLOW);
        lit("br_t5_alu", asnap[5], 5'b00011);
        CON_FF = 1'b1;
        run_instr(32'h98000003, 0, 0, 1'b0);
        lit("br_tk_t6", snap[6], ZLOW | PCIN);
        CON_FF = 1'b0;

        run_instr(32'hF8000000, 0, 0, 1'b0);
        lit("ill_t3", snap[3], ILL);
        lit("ill_no_t4", cnt[4], 0);
        lit("ill_end_step", 32'(step), 32'd0);

        run_instr(32'h18000000, 0, 0, 1'b1);
        lit("stop_add_t5", snap[5], ZLOW | GRA | RIN);
        lit("stop_halt_step", 32'(step), 32'd15);
        lit("stop_halt_run", 32'(run), 32'd0);
        stop = 1'b0;
        do_reset();
        lit("stop_reset_step", 32'(step), 32'd0);

        run_instr(32'hD8000000, 0, 0, 1'b0);
        lit("halt_step", 32'(step), 32'd15);
        repeat (20) tick();
        lit("halt_hold_step", 32'(step), 32'd15);
        lit("halt_hold_run", 32'(run), 32'd0);
        do_reset();
        lit("halt_reset_step", 32'(step), 32'd0);
        lit("halt_reset_run", 32'(run), 32'd1);

        IR = 32'h18000000;
        mem_done = 1'b1;
        n = 0;
        while (step != 4'd4 && n < 20) begin
            tick();
            n++;
        end
        lit("rst_reach_t4", 32'(step), 32'd4);
        reset = 1'b1;
        #1;
        lit("rst_t4_rin_write", {30'd0, Rin, Write}, 32'd0);
        tick();
        lit("rst_t4_step", 32'(step), 32'd0);
        reset = 1'b0;

        run_instr(32'h08000000, 0, 0, 1'b0);
        lit("ldi_t5", snap[5], ZLOW | GRA | RIN);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control-unit FSM that sits directly upstream of the register select-and-encode stage.
- Steps each instruction through fetch (T0–T2) and execute (T3–T7).
- Drives the Gra/Grb/Grc/Rin/Rout/BAout strobes and the datapath register, ALU and memory strobes from the IR opcode.
- Pauses on a memory-done handshake and supports halt/stop.

Parameters:
- OPW, 5, opcode width, taken from IR[31:27].
- ALUW, 5, width of the alu_op output.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; forces state to T0, strobes low.
- IR  in  32  instruction register contents (from IR register loaded by IRin).
- CON_FF  in  1  branch condition flip-flop result.
- mem_done  in  1  memory read/write completed this cycle.
- stop  in  1  request halt at next instruction boundary.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  select-and-encode strobes.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, CONin  out  1 each  datapath strobes.
- alu_op  out  5  ALU operation code.
- run  out  1  high unless halted.
- illegal  out  1  pulses in T3 for an unsupported opcode.
- step  out  4  current state encoding: T0..T7 = 0..7, HALT = 15.

Behaviour:
- **State and output timing**
  - State is a registered 4-bit value. All strobes are decoded combinationally from state and IR (Moore in state, qualified by opcode).
  - Any strobe not listed for a state is 0.
- **Reset**
  - Reset asserted: next state is T0, run=1.
  - All strobes are forced 0 while reset is high; step reads 0 after the edge.
  - Reset mid-instruction or mid-wait aborts the instruction with no Write/Rin in the reset cycle.
- **Opcodes** (IR[31:27])
  - ld 00000, ldi 00001, st 00010.
  - ALU reg-reg 00011–01011: add, sub, and, or, shr, shra, shl, ror, rol.
  - addi 01100, andi 01101, ori 01110.
  - br 10011, nop 11010, halt 11011.
  - Any other opcode: illegal=1 in T3, then behaves as nop.
- **alu_op**
  - reg-reg: alu_op = opcode.
  - addi/andi/ori: alu_op = add/and/or code (00011/00101/00110).
  - Address and branch-target calculation: add (00011).
- **Fetch (all instructions)**
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin in the first T1 cycle only. Read and MDRin are held every T1 cycle; remain in T1 until mem_done=1, then go to T2.
  - T2: MDRout, IRin.
- **Execute, by instruction class**
  - **reg-reg**
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, alu_op, Zin.
    - T5: Zlowout, Gra, Rin; then T0.
  - **immediate**
    - T3: Grb, Rout, Yin.
    - T4: Cout, alu_op, Zin.
    - T5: Zlowout, Gra, Rin; then T0.
  - **ld/ldi/st**
    - T3: Grb, BAout, Yin.
    - T4: Cout, add, Zin.
    - ldi T5: Zlowout, Gra, Rin; then T0.
    - ld/st T5: Zlowout, MARin.
    - ld T6: Read, MDRin; hold until mem_done.
    - ld T7: MDRout, Gra, Rin; then T0.
    - st T6: Gra, Rout, MDRin (Read=0 selects bus).
    - st T7: MDRout, Write; hold until mem_done, then T0.
  - **br**
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, add, Zin.
    - T6: Zlowout, and PCin only if CON_FF=1; then T0.
  - **nop/illegal**: T3 then T0.
  - **halt**: T3 then HALT.
    - HALT: run=0, all strobes 0, remains until reset.
- **stop**
  - Sampled on every transition into T0.
  - If stop=1, next state is HALT instead of T0; the in-flight instruction always completes.
- **Wait states**
  - mem_done is ignored outside T1, ld T6 and st T7.
  - If mem_done=1 in the first cycle of a wait state, that state lasts exactly 1 cycle.
- **Exclusivity**: Rin and Rout are never both 1; exactly one of Gra/Grb/Grc is 1 whenever Rin or Rout is 1.

Test Plan:
1. Reset, then IR=0x691FFFFD (andi), mem_done tied 1:
   - T0..T5 take 6 cycles total.
   - T3: Grb=1, Rout=1.
   - T4: Cout=1, alu_op=00101.
   - T5: Gra=1, Rin=1; then step=0.
2. IR=0x18000000 (add), mem_done low 3 cycles in T1:
   - T1 lasts 4 cycles; PCin only in the first; Read held throughout.
   - T4: Grc=1, Rout=1, alu_op=00011.
3. IR=ld 0x00800005:
   - T6 waits 2 cycles on mem_done.
   - T7: Gra=1, Rin=1.
   - Instruction spans T0..T7.
4. IR=st 0x10800005:
   - T6: Gra=1, Rout=1, MDRin=1.
   - T7: Write=1 until mem_done; no Rin anywhere.
5. IR=br 0x98000003:
   - With CON_FF=0, T6 has PCin=0.
   - With CON_FF=1, T6 has PCin=1.
6. Control and errors:
   - halt opcode 0xD8000000: step=15, run=0; stays halted 20 cycles until reset, which returns step=0.
   - stop=1 mid-add: add completes (Rin in T5), then HALT.
   - IR opcode 11111: illegal=1 in T3, then T0.
   - reset asserted in T4: next step=0, no Rin/Write in that cycle.
